// File: rtl/fifo_to_between.sv
`default_nettype none
// ============================================================================
// Module   : fifo_to_between
// Purpose  : Pops bytes from an upstream FIFO, folds each one into a running
//            CRC-8 (poly 0x07), then sends it over t0..t7 using a four-phase
//            tsent/trecieve handshake with per-phase timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_to_between #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  input  logic       trecieve,
  output logic       fifo_re,
  output logic       t0,
  output logic       t1,
  output logic       t2,
  output logic       t3,
  output logic       t4,
  output logic       t5,
  output logic       t6,
  output logic       t7,
  output logic       tsent,
  output logic       isFinish,
  output logic [7:0] CRC,
  output logic [3:0] error
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_READ    = 3'd1;
  localparam logic [2:0] c_ST_LATCH   = 3'd2;
  localparam logic [2:0] c_ST_CRC     = 3'd3;
  localparam logic [2:0] c_ST_SEND    = 3'd4;
  localparam logic [2:0] c_ST_RELEASE = 3'd5;

  localparam logic [7:0] c_POLY    = 8'h07;
  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic [7:0] r_byte;
  logic [2:0] r_bit_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_crc;
  logic [2:0] r_err;

  logic [7:0] w_cnt_inc;
  logic       w_cnt_expired;
  logic       w_fb;
  logic [7:0] w_crc_next;
  logic       w_spurious_ack;

  // The phase counter counts the current cycle too, so a phase lasts at most
  // TIMEOUT enabled cycles.
  assign w_cnt_inc     = r_cnt + 8'd1;
  assign w_cnt_expired = (w_cnt_inc == c_TIMEOUT);

  assign w_fb       = r_byte[r_bit_idx] ^ r_crc[7];
  assign w_crc_next = {r_crc[6:0], 1'b0} ^ (w_fb ? c_POLY : 8'h00);

  assign w_spurious_ack = trecieve &&
                          ((r_state == c_ST_READ) ||
                           (r_state == c_ST_LATCH) ||
                           (r_state == c_ST_CRC));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else if (enable) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (!trecieve && !fifo_empty) begin
          w_state_next = c_ST_READ;
        end
      end
      c_ST_READ:  w_state_next = c_ST_LATCH;
      c_ST_LATCH: w_state_next = c_ST_CRC;
      c_ST_CRC: begin
        if (r_bit_idx == 3'd0) begin
          w_state_next = c_ST_SEND;
        end
      end
      c_ST_SEND: begin
        // An expiring counter beats an acknowledge arriving in the same cycle.
        if (w_cnt_expired) begin
          w_state_next = c_ST_IDLE;
        end else if (trecieve) begin
          w_state_next = c_ST_RELEASE;
        end
      end
      c_ST_RELEASE: begin
        if (!trecieve || w_cnt_expired) begin
          w_state_next = c_ST_IDLE;
        end
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  // Datapath: byte register, CRC shifter, phase counter and sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte    <= 8'h00;
      r_bit_idx <= 3'd0;
      r_cnt     <= 8'h00;
      r_crc     <= 8'h00;
      r_err     <= 3'b000;
    end else if (enable) begin
      case (r_state)
        c_ST_LATCH: begin
          r_byte    <= fifo_data;
          r_bit_idx <= 3'd7;
        end
        c_ST_CRC: begin
          r_crc     <= w_crc_next;
          r_bit_idx <= r_bit_idx - 3'd1;
        end
        c_ST_SEND: begin
          if (w_cnt_expired) begin
            r_cnt    <= 8'h00;
            r_err[0] <= 1'b1;
          end else if (trecieve) begin
            r_cnt <= 8'h00;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        c_ST_RELEASE: begin
          if (!trecieve) begin
            r_cnt <= 8'h00;
          end else if (w_cnt_expired) begin
            r_cnt    <= 8'h00;
            r_err[1] <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
        end
      endcase
      if (w_spurious_ack) begin
        r_err[2] <= 1'b1;
      end
    end
  end

  // Output decode; fifo_re is gated so a frozen READ never pops
  always_comb begin
    fifo_re  = 1'b0;
    tsent    = 1'b0;
    isFinish = 1'b0;
    case (r_state)
      c_ST_IDLE: isFinish = 1'b1;
      c_ST_READ: fifo_re  = enable;
      c_ST_SEND: tsent    = 1'b1;
      default: begin
      end
    endcase
  end

  assign {t0, t1, t2, t3, t4, t5, t6, t7} = r_byte;
  assign CRC   = r_crc;
  assign error = {1'b0, r_err};

endmodule
`default_nettype wire

// File: tb/tb_fifo_to_between.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_to_between
// Purpose  : Directed bench for fifo_to_between with a FIFO model and a
//            byte/CRC scoreboard checked whenever tsent rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_to_between;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       trecieve;
  logic       fifo_re;
  logic       t0, t1, t2, t3, t4, t5, t6, t7;
  logic       tsent;
  logic       isFinish;
  logic [7:0] CRC;
  logic [3:0] error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  fifo_mem [0:63];
  int          n_push = 0;
  int          n_pop  = 0;
  logic [7:0]  model_crc = 8'h00;
  logic [15:0] exp_q [$];

  fifo_to_between #(.TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .trecieve(trecieve), .fifo_re(fifo_re),
    .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
    .tsent(tsent), .isFinish(isFinish), .CRC(CRC), .error(error)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after the pop strobe
  assign fifo_empty = (n_push == n_pop);
  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_data <= fifo_mem[n_pop[5:0]];
      n_pop     <= n_pop + 1;
    end
  end

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[n_push[5:0]] = b;
    n_push++;
    model_crc = crc8(model_crc, b);
    exp_q.push_back({b, model_crc});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_crc = 8'h00;
    exp_q.delete();
  endtask

  // Waits (bounded) for tsent, then pops and compares the scoreboard entry.
  task automatic wait_tsent(output int cyc, output int res);
    logic [15:0] e;
    cyc = 0;
    res = 0;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (fifo_re) res++;
      if (tsent) break;
    end
    check("tsent_seen", 32'(tsent), 32'd1);
    if (tsent) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL scoreboard observed=byte expected=none");
      end else begin
        e = exp_q.pop_front();
        check("t_lines", 32'({t0, t1, t2, t3, t4, t5, t6, t7}), 32'(e[15:8]));
        check("crc_at_tsent", 32'(CRC), 32'(e[7:0]));
      end
    end
  endtask

  // Receiver that acknowledges now and drops trecieve once it sees tsent low.
  task automatic ack_hs();
    trecieve = 1'b1;
    tick();
    check("tsent_drop", 32'(tsent), 32'd0);
    tick();
    trecieve = 1'b0;
    tick();
    check("idle_after_hs", 32'(isFinish), 32'd1);
  endtask

  initial begin
    int cyc, res, n, pop0;
    reset    = 1'b1;
    enable   = 1'b1;
    trecieve = 1'b0;

    tick();
    check("rst_tsent",    32'(tsent),    32'd0);
    check("rst_fifo_re",  32'(fifo_re),  32'd0);
    check("rst_t_lines",  32'({t0, t1, t2, t3, t4, t5, t6, t7}), 32'd0);
    check("rst_isFinish", 32'(isFinish), 32'd1);
    check("rst_crc",      32'(CRC),      32'd0);
    check("rst_error",    32'(error),    32'd0);
    reset = 1'b0;
    tick();

    // Single byte 0x31, acknowledge two cycles after tsent
    push_byte(8'h31);
    wait_tsent(cyc, res);
    check("b1_latency", 32'(cyc), 32'd11);
    check("b1_re_pulses", 32'(res), 32'd1);
    check("b1_crc_const", 32'(CRC), 32'h97);
    tick();
    check("b1_hold1", 32'(tsent), 32'd1);
    tick();
    check("b1_hold2", 32'(tsent), 32'd1);
    ack_hs();

    // Two bytes back to back, immediate acknowledge
    do_reset();
    push_byte(8'h31);
    push_byte(8'h32);
    wait_tsent(cyc, res);
    ack_hs();
    wait_tsent(cyc, res);
    check("b2_period", 32'(cyc + 3), 32'd14);
    check("b2_re_pulses", 32'(res), 32'd1);
    ack_hs();
    check("b2_crc_const", 32'(CRC), 32'h72);
    check("b2_error", 32'(error), 32'd0);

    // Receiver never acknowledges: SEND timeout, then next byte still goes
    push_byte(8'h5A);
    wait_tsent(cyc, res);
    n = 1;
    while (tsent && n < 50) begin
      tick();
      if (tsent) n++;
    end
    check("to_tsent_cycles", 32'(n), 32'd10);
    check("to_error", 32'(error), 32'h1);
    check("to_idle", 32'(isFinish), 32'd1);
    push_byte(8'hA7);
    wait_tsent(cyc, res);
    check("to_next_latency", 32'(cyc), 32'd11);
    ack_hs();
    check("to_error_sticky", 32'(error), 32'h1);

    // trecieve stuck high: RELEASE timeout, then IDLE waits for it to fall
    do_reset();
    push_byte(8'h3C);
    wait_tsent(cyc, res);
    trecieve = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (isFinish) break;
      n++;
    end
    check("rel_cycles", 32'(n), 32'd10);
    check("rel_error", 32'(error), 32'h2);
    push_byte(8'h0F);
    res = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fifo_re || !isFinish) res++;
    end
    check("rel_wait_idle", 32'(res), 32'd0);
    trecieve = 1'b0;
    wait_tsent(cyc, res);
    check("rel_next_latency", 32'(cyc), 32'd11);
    ack_hs();
    check("rel_error_final", 32'(error), 32'h2);

    // enable low for 5 cycles during CRC
    do_reset();
    push_byte(8'h31);
    res = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fifo_re) res++;
    end
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fifo_re || (CRC !== 8'h12)) n++;
    end
    check("en_frozen", 32'(n), 32'd0);
    enable = 1'b1;
    wait_tsent(cyc, n);
    check("en_latency", 32'(8 + 5 + cyc), 32'd16);
    check("en_re_pulses", 32'(res + n), 32'd1);
    check("en_crc_const", 32'(CRC), 32'h97);
    ack_hs();

    // enable low during READ, then a spurious acknowledge during CRC
    pop0 = n_pop;
    push_byte(8'hC3);
    tick();
    check("rd_re_high", 32'(fifo_re), 32'd1);
    enable = 1'b0;
    #1;
    check("rd_re_gated", 32'(fifo_re), 32'd0);
    tick();
    tick();
    enable = 1'b1;
    tick();
    tick();
    trecieve = 1'b1;
    tick();
    trecieve = 1'b0;
    wait_tsent(cyc, res);
    check("sp_latency", 32'(cyc), 32'd7);
    check("sp_single_pop", 32'(n_pop - pop0), 32'd1);
    check("sp_error", 32'(error), 32'h4);
    ack_hs();

    // Asynchronous reset while tsent is high
    push_byte(8'h81);
    wait_tsent(cyc, res);
    #1;
    reset = 1'b1;
    #1;
    check("ar_tsent",    32'(tsent),    32'd0);
    check("ar_fifo_re",  32'(fifo_re),  32'd0);
    check("ar_crc",      32'(CRC),      32'd0);
    check("ar_error",    32'(error),    32'd0);
    check("ar_isFinish", 32'(isFinish), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_to_between.md
# fifo_to_between

Transmit-side counterpart of the byte receiver that feeds the FIFO. The block pops bytes from an upstream FIFO and runs a running serial CRC-8 over each byte. It then presents each byte on the eight parallel lines t0..t7 and moves it to the receiver with the four-phase tsent/trecieve handshake. It sits between the outgoing FIFO and the inter-board link, and checks the handshake with per-phase timeouts.

## Interface
- TIMEOUT, 255: maximum cycles to wait in either handshake phase before abort; 1..255, 8-bit counter.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; returns the FSM to IDLE and all outputs to reset values.
- enable  input  1  1 = FSM advances; 0 = all state and outputs hold, and fifo_re is forced to 0.
- fifo_empty  input  1  upstream FIFO has no data.
- fifo_data  input  8  FIFO read data; valid the cycle after fifo_re; held by the FIFO until the next fifo_re.
- trecieve  input  1  receiver acknowledge.
- fifo_re  output  1  one-cycle FIFO pop strobe.
- t0..t7  output  1 each  byte lines; t0 = bit 7 (MSB) … t7 = bit 0.
- tsent  output  1  byte-valid request.
- isFinish  output  1  1 while in IDLE.
- CRC  output  8  running CRC-8 over all bytes sent since reset.
- error  output  4  sticky error flags, cleared only by reset.

## Operation
- Reset values:
  - Outputs: tsent=0, fifo_re=0, t0..t7=0, isFinish=1, CRC=8'h00, error=4'h0.
  - Internal: state=IDLE, counters=0.
- State machine, advancing only when enable=1:
  - IDLE: isFinish=1. If fifo_empty=0 and trecieve=0, go to READ. If trecieve=1, wait in IDLE.
  - READ: fifo_re=1 for this cycle only; go to LATCH.
  - LATCH: capture fifo_data into the byte register, which drives t0..t7. Set bit index to 7 and go to CRC.
  - CRC: shift one bit per cycle, MSB first, for 8 cycles (bit 7 down to bit 0), then go to SEND.
    - fb = bit ^ CRC[7].
    - CRC = {CRC[6:0],0} ^ (fb ? 8'h07 : 8'h00).
  - SEND: tsent=1 and the timeout counter counts up.
    - If trecieve=1: tsent=0, clear the counter, go to RELEASE.
    - If the counter reaches TIMEOUT: set error[0], tsent=0, go to IDLE. The byte is dropped, but its CRC contribution remains.
  - RELEASE: tsent=0 and the timeout counter counts up.
    - If trecieve=0: go to IDLE.
    - If the counter reaches TIMEOUT: set error[1], go to IDLE.
- CRC rules:
  - Polynomial x^8+x^2+x+1, initial value 0x00, no reflection, no final XOR.
  - CRC accumulates across bytes and is never cleared except by reset.
- Error bits:
  - error[2]: set if trecieve=1 in READ, LATCH or CRC. The spurious acknowledge is ignored and the FSM continues.
  - error[3]: always 0.
- t0..t7 hold from LATCH until the next LATCH, including through an abort.
- The upper-layer default state maps to IDLE.

## Timing
- Byte latency, counted in enabled cycles from the IDLE cycle that sees fifo_empty=0:
  - fifo_re is high in cycle 1 (READ).
  - Data is latched in cycle 2 (LATCH).
  - CRC runs in cycles 3–10; CRC is final at the end of cycle 10.
  - tsent rises in cycle 11.
- tsent falls on the edge after trecieve is sampled high.
- After trecieve is sampled low, the FSM is back in IDLE on the next edge. The minimum byte period is therefore 14 cycles with an immediate acknowledge.
- Throughput limit is 1 byte per 14 cycles; there is no pipelining across bytes.
- Simultaneous fifo_empty=0 and trecieve=1 in IDLE: stay in IDLE, no error flag.
- A timeout in SEND takes priority over trecieve arriving in the same cycle only when the counter equals TIMEOUT; otherwise the acknowledge wins.
- enable low mid-byte freezes the FSM; fifo_re is never high for more than one enabled cycle per byte.
- reset asserted mid-handshake drops tsent and fifo_re immediately (asynchronously) and clears CRC.

## Test plan
- Single byte, FIFO holds 0x31, receiver acknowledges 2 cycles after tsent -> fifo_re pulses once; t0..t7 = 0,0,1,1,0,0,0,1; CRC=0x97 before tsent rises; isFinish returns to 1.
- Two bytes 0x31 then 0x32, immediate acknowledge -> two handshakes, each byte ≥14 cycles apart; final CRC=0x72; error=0.
- Receiver never acknowledges, TIMEOUT=10 -> tsent high for 10 cycles, then 0; error=4'b0001; the next FIFO byte is still sent normally.
- trecieve stuck high after acknowledge, TIMEOUT=10 -> error=4'b0010 after 10 cycles in RELEASE; FSM waits in IDLE until trecieve falls.
- enable pulled low for 5 cycles during CRC with byte 0x31 -> CRC state frozen, fifo_re stays 0, latency grows by exactly 5, final CRC=0x97.
- reset asserted while tsent=1 -> tsent=0, CRC=0x00, error=0, isFinish=1 without waiting for a clock edge.
